// File: rtl/ras_driver_pkg.sv
// Shared definitions for the RAS predecoder: opcodes, RAS operation encoding,
// link-register test and FSM state type.
// Configuration macro: RAS_DRIVER_COROUTINE_EN (enables SWAP classification).
`ifndef XLEN
`define XLEN 32
`endif

package ras_driver_pkg;

  localparam int unsigned XLEN = `XLEN;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  typedef enum logic [1:0] {RAS_NONE, RAS_PUSH, RAS_POP, RAS_SWAP} ras_op_t;

  typedef enum logic [0:0] {StIdle, StSwapPush} ras_state_e;

  // x1 (ra) and x5 (t0) are the RISC-V link registers.
  function automatic logic is_link_reg(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/ras_classify.sv
// Combinational classifier: instruction word -> RAS operation, JAL flag and
// sign-extended J-immediate.
// Ports: inst_i (instruction), op_o (ras_op_t), is_jal_o, j_imm_o.
// Configuration macro: RAS_DRIVER_COROUTINE_EN (rd-link/rs1-link/rd!=rs1 -> SWAP,
// otherwise PUSH).
module ras_classify
  import ras_driver_pkg::*;
(
  input  logic [31:0]     inst_i,
  output ras_op_t         op_o,
  output logic            is_jal_o,
  output logic [XLEN-1:0] j_imm_o
);

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic        rd_link;
  logic        rs1_link;
  logic [20:0] imm21;

  assign opcode   = inst_i[6:0];
  assign rd       = inst_i[11:7];
  assign rs1      = inst_i[19:15];
  assign rd_link  = is_link_reg(rd);
  assign rs1_link = is_link_reg(rs1);
  assign is_jal_o = (opcode == OPC_JAL);

  assign imm21   = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign j_imm_o = {{(XLEN-21){imm21[20]}}, imm21};

  always_comb begin
    op_o = RAS_NONE;
    if (opcode == OPC_JAL) begin
      if (rd_link) op_o = RAS_PUSH;
    end else if (opcode == OPC_JALR) begin
      if (!rd_link && rs1_link) begin
        op_o = RAS_POP;
      end else if (rd_link && !rs1_link) begin
        op_o = RAS_PUSH;
      end else if (rd_link && rs1_link) begin
        if (rd == rs1) begin
          op_o = RAS_PUSH;
        end else begin
`ifdef RAS_DRIVER_COROUTINE_EN
          op_o = RAS_SWAP;
`else
          op_o = RAS_PUSH;
`endif
        end
      end
    end
  end

endmodule

// File: rtl/ras_driver.sv
// One-entry registered fetch predecoder driving the return address stack.
// Ports: clock/reset (async active-high), flush; fetch side if_valid/if_ready/
// if_inst/if_pc; RAS side ras_top (in), ras_push/ras_pop/ras_link_pc (out);
// decode side out_valid/out_ready/out_pc/out_npc/out_is_call/out_is_ret.
// Configuration macro: RAS_DRIVER_COROUTINE_EN (SWAP split into pop, then push
// in a SWAP_PUSH cycle; without it the FSM never leaves IDLE).
module ras_driver
  import ras_driver_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] ras_top,
  output logic            ras_push,
  output logic            ras_pop,
  output logic [XLEN-1:0] ras_link_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_npc,
  output logic            out_is_call,
  output logic            out_is_ret
);

  ras_op_t         cls_op;
  logic            cls_is_jal;
  logic [XLEN-1:0] cls_j_imm;

  ras_classify u_classify (
    .inst_i   (if_inst),
    .op_o     (cls_op),
    .is_jal_o (cls_is_jal),
    .j_imm_o  (cls_j_imm)
  );

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] npc_q, npc_d;
  logic            use_ras_q, use_ras_d;
  ras_op_t         op_q, op_d;
  logic [XLEN-1:0] swap_pc_q, swap_pc_d;
  ras_state_e      state_q, state_d;

  logic fire;
  logic accept;

  assign out_valid   = valid_q && (state_q == StIdle);
  assign fire        = out_valid && out_ready && !flush;
  assign accept      = if_valid && if_ready;
  assign out_pc      = pc_q;
  // POP/SWAP targets follow the live top of stack; everything else is precomputed.
  assign out_npc     = use_ras_q ? ras_top : npc_q;
  assign out_is_call = (op_q == RAS_PUSH) || (op_q == RAS_SWAP);
  assign out_is_ret  = (op_q == RAS_POP) || (op_q == RAS_SWAP);

  // Entry register next state.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    use_ras_d = use_ras_q;
    op_d      = op_q;
    swap_pc_d = swap_pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else begin
      if (fire && (op_q == RAS_SWAP)) swap_pc_d = pc_q;
      if (accept) begin
        valid_d   = 1'b1;
        pc_d      = if_pc;
        npc_d     = cls_is_jal ? (if_pc + cls_j_imm) : (if_pc + XLEN'(4));
        use_ras_d = (cls_op == RAS_POP) || (cls_op == RAS_SWAP);
        op_d      = cls_op;
      end else if (fire) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      npc_q     <= '0;
      use_ras_q <= 1'b0;
      op_q      <= RAS_NONE;
      swap_pc_q <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      npc_q     <= npc_d;
      use_ras_q <= use_ras_d;
      op_q      <= op_d;
      swap_pc_q <= swap_pc_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = StIdle;
`ifdef RAS_DRIVER_COROUTINE_EN
    if (!flush && (state_q == StIdle) && fire && (op_q == RAS_SWAP)) state_d = StSwapPush;
`endif
  end

  // FSM outputs. The RAS ignores simultaneous push+pop, so SWAP pushes a cycle later.
  always_comb begin
    if_ready    = (state_q == StIdle) && (!valid_q || out_ready) && !flush;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    ras_link_pc = pc_q;
    if (!flush) begin
      if (state_q == StSwapPush) begin
        ras_push    = 1'b1;
        ras_link_pc = swap_pc_q;
      end else if (fire) begin
        case (op_q)
          RAS_PUSH: ras_push = 1'b1;
          RAS_POP:  ras_pop  = 1'b1;
          RAS_SWAP: ras_pop  = 1'b1;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ras_driver.sv
// Self-checking bench for ras_driver: directed scenarios followed by random
// traffic compared against a transaction-level reference model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_ras_driver;

  localparam int XL = `XLEN;
  localparam int K_NONE = 0;
  localparam int K_PUSH = 1;
  localparam int K_POP  = 2;
  localparam int K_SWAP = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          if_valid;
  logic          if_ready;
  logic [31:0]   if_inst;
  logic [XL-1:0] if_pc;
  logic [XL-1:0] ras_top;
  logic          ras_push;
  logic          ras_pop;
  logic [XL-1:0] ras_link_pc;
  logic          out_valid;
  logic          out_ready;
  logic [XL-1:0] out_pc;
  logic [XL-1:0] out_npc;
  logic          out_is_call;
  logic          out_is_ret;

  ras_driver dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .ras_top     (ras_top),
    .ras_push    (ras_push),
    .ras_pop     (ras_pop),
    .ras_link_pc (ras_link_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_npc     (out_npc),
    .out_is_call (out_is_call),
    .out_is_ret  (out_is_ret)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the held entry and a pending second half of a swap.
  logic          m_valid;
  logic [XL-1:0] m_pc;
  logic [XL-1:0] m_npc;
  int            m_kind;
  logic          m_swap;
  logic [XL-1:0] m_swap_pc;

  logic e_if_ready, e_out_valid, e_fire, e_push, e_pop;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int classify(input logic [31:0] i);
    logic [4:0] rd, rs1;
    logic ld, ls;
    rd  = i[11:7];
    rs1 = i[19:15];
    ld  = (rd == 5'd1) || (rd == 5'd5);
    ls  = (rs1 == 5'd1) || (rs1 == 5'd5);
    if (i[6:0] == 7'b1101111) return ld ? K_PUSH : K_NONE;
    if (i[6:0] == 7'b1100111) begin
      if (!ld && ls) return K_POP;
      if (ld && !ls) return K_PUSH;
      if (ld && ls) begin
`ifdef RAS_DRIVER_COROUTINE_EN
        return (rd == rs1) ? K_PUSH : K_SWAP;
`else
        return K_PUSH;
`endif
      end
    end
    return K_NONE;
  endfunction

  function automatic logic [XL-1:0] static_npc(input logic [31:0] i, input logic [XL-1:0] pc);
    logic signed [XL-1:0] imm;
    if (i[6:0] == 7'b1101111) begin
      imm = XL'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      return pc + imm;
    end
    return pc + XL'(4);
  endfunction

  task automatic model_clear();
    m_valid = 1'b0;
    m_swap  = 1'b0;
  endtask

  // Apply inputs for this cycle (called just after a falling edge) and compare.
  task automatic drive(input logic fl, input logic iv, input logic [31:0] inst,
                       input logic [XL-1:0] pc, input logic [XL-1:0] top, input logic ordy);
    flush = fl; if_valid = iv; if_inst = inst; if_pc = pc; ras_top = top; out_ready = ordy;
    #1;
    e_out_valid = m_valid && !m_swap;
    e_if_ready  = !m_swap && (!m_valid || ordy) && !fl;
    e_fire      = e_out_valid && ordy && !fl;
    e_push      = (e_fire && m_kind == K_PUSH) || (m_swap && !fl);
    e_pop       = e_fire && (m_kind == K_POP || m_kind == K_SWAP);
    check_eq("if_ready", if_ready, e_if_ready);
    check_eq("out_valid", out_valid, e_out_valid);
    check_eq("ras_push", ras_push, e_push);
    check_eq("ras_pop", ras_pop, e_pop);
    if (e_push) check_eq("ras_link_pc", ras_link_pc, m_swap ? m_swap_pc : m_pc);
    if (e_out_valid) begin
      check_eq("out_pc", out_pc, m_pc);
      check_eq("out_npc", out_npc, (m_kind == K_POP || m_kind == K_SWAP) ? top : m_npc);
      check_eq("out_is_call", out_is_call, m_kind == K_PUSH || m_kind == K_SWAP);
      check_eq("out_is_ret", out_is_ret, m_kind == K_POP || m_kind == K_SWAP);
    end
  endtask

  // Advance one clock and update the model with what was accepted/consumed.
  task automatic step();
    logic nswap;
    @(posedge clock);
    if (flush) begin
      model_clear();
    end else begin
      nswap = e_fire && (m_kind == K_SWAP);
      if (nswap) m_swap_pc = m_pc;
      if (if_valid && e_if_ready) begin
        m_valid = 1'b1;
        m_pc    = if_pc;
        m_kind  = classify(if_inst);
        m_npc   = static_npc(if_inst, if_pc);
      end else if (e_fire) begin
        m_valid = 1'b0;
      end
      m_swap = nswap;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    flush = 1'b0; if_valid = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_ras_push", ras_push, 1'b0);
    check_eq("rst_ras_pop", ras_pop, 1'b0);
    check_eq("rst_out_pc", out_pc, '0);
    check_eq("rst_out_npc", out_npc, '0);
    check_eq("rst_link_pc", ras_link_pc, '0);
    check_eq("rst_is_call", out_is_call, 1'b0);
    check_eq("rst_is_ret", out_is_ret, 1'b0);
    check_eq("rst_if_ready", if_ready, 1'b1);
    model_clear();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd5;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 3))
      0:       return {r[31:12], pick_reg(), 7'b1101111};
      1:       return {r[31:20], pick_reg(), 3'b000, pick_reg(), 7'b1100111};
      2:       return {r[31:7], 7'b0010011};
      default: return r;
    endcase
  endfunction

  localparam logic [31:0] JAL_X1_16 = 32'h010000EF;
  localparam logic [31:0] RET       = 32'h00008067;
  localparam logic [31:0] SWAP_INST = 32'h000280E7;
  localparam logic [31:0] ADDI      = 32'h00000013;

  initial begin
    logic [XL-1:0] rpc;
    model_clear();
    flush = 0; if_valid = 0; if_inst = '0; if_pc = '0; ras_top = '0; out_ready = 0;
    do_reset();

    // Call.
    drive(0, 1, JAL_X1_16, XL'('h100), '0, 1); step();
    drive(0, 0, ADDI, '0, '0, 1);
    check_eq("call_npc", out_npc, XL'('h110));
    check_eq("call_is_call", out_is_call, 1'b1);
    check_eq("call_push", ras_push, 1'b1);
    check_eq("call_link", ras_link_pc, XL'('h100));
    step();

    // Return.
    drive(0, 1, RET, XL'('h200), '0, 1); step();
    drive(0, 0, ADDI, '0, XL'('h104), 1);
    check_eq("ret_npc", out_npc, XL'('h104));
    check_eq("ret_pop", ras_pop, 1'b1);
    step();
    drive(0, 0, ADDI, '0, XL'('h104), 1);
    check_eq("ret_pop_once", ras_pop, 1'b0);
    step();

    // Stall for three cycles while holding a call.
    drive(0, 1, JAL_X1_16, XL'('h400), '0, 1); step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, ADDI, XL'('h500), '0, 0);
      check_eq("stall_no_push", ras_push, 1'b0);
      check_eq("stall_if_ready", if_ready, 1'b0);
      step();
    end
    drive(0, 0, ADDI, '0, '0, 1);
    check_eq("stall_fire_push", ras_push, 1'b1);
    step();
    drive(0, 0, ADDI, '0, '0, 1);
    check_eq("stall_push_once", ras_push, 1'b0);
    step();

    // Swap.
    drive(0, 1, SWAP_INST, XL'('h300), '0, 1); step();
    drive(0, 0, ADDI, '0, XL'('h500), 1);
`ifdef RAS_DRIVER_COROUTINE_EN
    check_eq("swap_pop", ras_pop, 1'b1);
    check_eq("swap_npc", out_npc, XL'('h500));
    check_eq("swap_no_push_yet", ras_push, 1'b0);
    step();
    drive(0, 0, ADDI, '0, XL'('h500), 1);
    check_eq("swap_push", ras_push, 1'b1);
    check_eq("swap_link", ras_link_pc, XL'('h300));
    check_eq("swap_if_ready", if_ready, 1'b0);
    step();
`else
    check_eq("swap_as_push", ras_push, 1'b1);
    check_eq("swap_no_pop", ras_pop, 1'b0);
    check_eq("swap_npc_seq", out_npc, XL'('h304));
    step();
    drive(0, 0, ADDI, '0, XL'('h500), 1);
    check_eq("swap_no_second_push", ras_push, 1'b0);
    step();
`endif

    // Flush during the swap push cycle.
    drive(0, 1, SWAP_INST, XL'('h300), '0, 1); step();
    drive(0, 0, ADDI, '0, XL'('h500), 1); step();
    drive(1, 1, ADDI, XL'('h600), XL'('h500), 1);
    check_eq("flush_no_push", ras_push, 1'b0);
    step();
    drive(0, 0, ADDI, '0, '0, 1);
    check_eq("flush_out_valid", out_valid, 1'b0);
    check_eq("flush_if_ready", if_ready, 1'b1);
    step();

    // Non-branch with PC wrap.
    drive(0, 1, ADDI, XL'('hFFFFFFFC), '0, 1); step();
    drive(0, 0, ADDI, '0, XL'('h1234), 1);
    check_eq("wrap_npc", out_npc, XL'(0));
    check_eq("wrap_no_push", ras_push, 1'b0);
    check_eq("wrap_no_pop", ras_pop, 1'b0);
    step();

    // Random traffic, with occasional asynchronous reset.
    for (int c = 0; c < 4000; c++) begin
      rpc = XL'($urandom()) & ~XL'(3);
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, rand_inst(), rpc,
            XL'($urandom()), $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
